// File: rtl/apb_irq_completer_if.sv
// APB3 bus bundle between the fabric initiator and the
// interrupt-controller register completer.
interface apb_irq_completer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel_i;
  logic              penable_i;
  logic              pwrite_i;
  logic [ADDR_W-1:0] paddr_i;
  logic [DATA_W-1:0] pwdata_i;
  logic [DATA_W-1:0] prdata_o;
  logic              pready_o;
  logic              pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i,
    output paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i,
    input  paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/apb_irq_completer.sv
// APB3 completer for the interrupt controller register bank,
// with trigger capture and registered priority arbitration.
module apb_irq_completer #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic               pclk_i,
  input  logic               rst_i,
  apb_irq_completer_if.slave apb,
  input  logic [3:0]         irq_trigger_i,
  output logic               interrupt_o,
  output logic [1:0]         irq_id_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state_q;
  state_t state;
  state_t state_d;

  logic [1:0]        cnt_q;
  logic              ctrl_q;
  logic [3:0]        status_q;
  logic [3:0]        mask_q;
  logic [2:0]        pth_q;
  logic [3:0][2:0]   pri_q;
  logic [DATA_W-1:0] prdata_q;
  logic [DATA_W-1:0] rd_val;

  logic [3:0] idx;
  logic       bad_hi;
  logic       err;
  logic       xfer;
  logic       ready;
  logic       wr_en;
  logic [3:0] clr;
  logic [3:0] elig;
  logic       any;
  logic [1:0] win_id;
  logic [2:0] win_pri;

  assign idx    = apb.paddr_i[3:0];
  assign bad_hi = |apb.paddr_i[ADDR_W-1:4];
  assign err    = bad_hi || (idx > 4'd8) ||
                  (apb.pwrite_i && idx == 4'd1);
  assign xfer   = apb.psel_i && apb.penable_i;

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // SETUP is the cycle in which the setup phase is on the bus
  always_comb begin
    state = state_q;
    if (state_q == IDLE && apb.psel_i && !apb.penable_i)
      state = SETUP;
    state_d = IDLE;
    case (state)
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        state_d = ACCESS;
        if (!apb.psel_i || (apb.penable_i && cnt_q == 2'd0))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ACCESS) && xfer && (cnt_q == 2'd0);
    wr_en = ready && apb.pwrite_i && !err;
    clr   = (wr_en && idx == 4'd2) ? apb.pwdata_i[3:0] : 4'h0;
  end

  assign apb.pready_o  = ready;
  assign apb.pslverr_o = ready && err;
  assign apb.prdata_o  = prdata_q;

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= 2'd0;
    else if (state == SETUP)
      cnt_q <= 2'(WAIT_STATES);
    else if (state == ACCESS && xfer && cnt_q != 2'd0)
      cnt_q <= cnt_q - 2'd1;
  end

  always_comb begin
    rd_val = '0;
    if (!bad_hi) begin
      case (idx)
        4'd0: rd_val[0]   = ctrl_q;
        4'd1: rd_val[2:0] = {interrupt_o, irq_id_o};
        4'd2: rd_val[3:0] = status_q;
        4'd3: rd_val[3:0] = mask_q;
        4'd4: rd_val[2:0] = pth_q;
        4'd5, 4'd6, 4'd7, 4'd8:
          rd_val[2:0] = pri_q[2'(idx - 4'd5)];
        default: rd_val = '0;
      endcase
    end
  end

  // ascending scan with strict compare keeps ties on the lowest index
  always_comb begin
    elig    = '0;
    any     = 1'b0;
    win_id  = 2'd0;
    win_pri = 3'd0;
    for (int n = 0; n < 4; n++) begin
      elig[n] = ctrl_q && status_q[n] && mask_q[n] &&
                (pri_q[n] > pth_q);
      if (elig[n] && (!any || pri_q[n] > win_pri)) begin
        any     = 1'b1;
        win_id  = 2'(n);
        win_pri = pri_q[n];
      end
    end
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q      <= 1'b0;
      status_q    <= 4'h0;
      mask_q      <= 4'h0;
      pth_q       <= 3'd0;
      pri_q       <= '0;
      prdata_q    <= '0;
      interrupt_o <= 1'b0;
      irq_id_o    <= 2'd0;
    end else begin
      status_q    <= (status_q & ~clr) | irq_trigger_i;
      interrupt_o <= any;
      irq_id_o    <= win_id;
      if (state_d == ACCESS)
        prdata_q <= rd_val;
      if (wr_en) begin
        case (idx)
          4'd0: ctrl_q <= apb.pwdata_i[0];
          4'd3: mask_q <= apb.pwdata_i[3:0];
          4'd4: pth_q  <= apb.pwdata_i[2:0];
          4'd5, 4'd6, 4'd7, 4'd8:
            pri_q[2'(idx - 4'd5)] <= apb.pwdata_i[2:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_irq_completer.sv
// Bench for apb_irq_completer: directed vector table, wait-state and
// reset corner sequences, then random traffic against a register model.
module tb_apb_irq_completer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  trig = '0;
  int          sel = 0;
  bit          rtrig = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic        int0, int1;
  logic [1:0]  id0, id1;
  logic [31:0] obs_rd;
  bit          obs_err;

  always #5 clk = ~clk;

  apb_irq_completer_if #(.ADDR_W(32), .DATA_W(32)) a0 ();
  apb_irq_completer_if #(.ADDR_W(32), .DATA_W(32)) a1 ();

  assign a0.psel_i    = psel && (sel == 0);
  assign a0.penable_i = penable;
  assign a0.pwrite_i  = pwrite;
  assign a0.paddr_i   = paddr;
  assign a0.pwdata_i  = pwdata;
  assign a1.psel_i    = psel && (sel == 1);
  assign a1.penable_i = penable;
  assign a1.pwrite_i  = pwrite;
  assign a1.paddr_i   = paddr;
  assign a1.pwdata_i  = pwdata;

  apb_irq_completer #(
    .WAIT_STATES(0), .ADDR_W(32), .DATA_W(32)
  ) u0 (
    .pclk_i(clk), .rst_i(rst), .apb(a0),
    .irq_trigger_i(trig), .interrupt_o(int0), .irq_id_o(id0)
  );

  apb_irq_completer #(
    .WAIT_STATES(2), .ADDR_W(32), .DATA_W(32)
  ) u2 (
    .pclk_i(clk), .rst_i(rst), .apb(a1),
    .irq_trigger_i(trig), .interrupt_o(int1), .irq_id_o(id1)
  );

  // reference model, one per DUT
  bit          m_ctrl [2];
  logic [3:0]  m_st   [2];
  logic [3:0]  m_mask [2];
  logic [2:0]  m_pth  [2];
  logic [2:0]  m_pri  [2][4];
  bit          e_int  [2];
  logic [1:0]  e_id   [2];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  tp;
    logic [3:0]  td;
    logic [31:0] rd;
    bit          er;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t V(bit w, logic [31:0] a, logic [31:0] d,
                             logic [3:0] tp, logic [3:0] td,
                             logic [31:0] rd, bit er);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.tp = tp; v.td = td;
    v.rd = rd; v.er = er;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void mreset();
    for (int d = 0; d < 2; d++) begin
      m_ctrl[d] = 0; m_st[d] = 0; m_mask[d] = 0; m_pth[d] = 0;
      e_int[d] = 0; e_id[d] = 0;
      for (int n = 0; n < 4; n++) m_pri[d][n] = 0;
    end
  endfunction

  function automatic void winner(int d, output bit v,
                                 output logic [1:0] id);
    int best;
    best = -1; v = 0; id = 0;
    for (int n = 0; n < 4; n++)
      if (m_ctrl[d] && m_st[d][n] && m_mask[d][n] &&
          m_pri[d][n] > m_pth[d] && int'(m_pri[d][n]) > best) begin
        best = int'(m_pri[d][n]); id = 2'(n); v = 1;
      end
  endfunction

  function automatic logic [31:0] mread(int d, logic [31:0] a);
    int i;
    i = int'(a[3:0]);
    if (a[31:4] != 0) return 0;
    if (i == 0) return {31'b0, m_ctrl[d]};
    if (i == 1) return {29'b0, e_int[d], e_id[d]};
    if (i == 2) return {28'b0, m_st[d]};
    if (i == 3) return {28'b0, m_mask[d]};
    if (i == 4) return {29'b0, m_pth[d]};
    if (i >= 5 && i <= 8) return {29'b0, m_pri[d][i-5]};
    return 0;
  endfunction

  function automatic bit merr(bit w, logic [31:0] a);
    return (a[31:4] != 0) || (a[3:0] > 8) || (w && a[3:0] == 1);
  endfunction

  // one clock: check outputs at negedge, advance model at posedge
  task automatic step(bit ep, bit commit);
    bit v;
    logic [1:0] id;
    logic [3:0] clr;
    int i;
    @(negedge clk);
    chk("pready", (sel == 1) ? a1.pready_o : a0.pready_o, ep);
    obs_rd  = (sel == 1) ? a1.prdata_o : a0.prdata_o;
    obs_err = (sel == 1) ? a1.pslverr_o : a0.pslverr_o;
    chk("int0", int0, e_int[0]);
    chk("id0", id0, e_id[0]);
    chk("int1", int1, e_int[1]);
    chk("id1", id1, e_id[1]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      winner(d, v, id);
      e_int[d] = v; e_id[d] = id;
    end
    clr = 0;
    if (commit) begin
      i = int'(paddr[3:0]);
      if (i == 0) m_ctrl[sel] = pwdata[0];
      if (i == 2) clr = pwdata[3:0];
      if (i == 3) m_mask[sel] = pwdata[3:0];
      if (i == 4) m_pth[sel] = pwdata[2:0];
      if (i >= 5 && i <= 8) m_pri[sel][i-5] = pwdata[2:0];
    end
    for (int d = 0; d < 2; d++)
      m_st[d] = (m_st[d] & ~((d == sel) ? clr : 4'h0)) | trig;
    #1;
    trig = rtrig ? 4'($urandom_range(0, 15) & $urandom_range(0, 15))
                 : 4'h0;
  endtask

  task automatic apb(bit w, logic [31:0] a, logic [31:0] d,
                     logic [3:0] td, output logic [31:0] rd,
                     output bit er, output logic [31:0] erd);
    int ws;
    ws = (sel == 1) ? 2 : 0;
    rd = 0; er = 0;
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    erd = mread(sel, a);
    step(0, 0);
    penable = 1;
    for (int k = 0; k <= ws; k++) begin
      if (k < ws) erd = mread(sel, a);
      if (k == ws) trig = trig | td;
      step(k == ws, (k == ws) && w && !merr(w, a));
      if (k == ws) begin rd = obs_rd; er = obs_err; end
    end
    psel = 0; penable = 0;
    step(0, 0);
  endtask

  initial begin
    logic [31:0] rd, erd, a, d;
    bit er, w;
    int r;

    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", a0.pready_o, 0);
    chk("rst_pslverr", a0.pslverr_o, 0);
    chk("rst_prdata", a0.prdata_o, 0);
    chk("rst_int", int0, 0);
    chk("rst_id", id0, 0);
    chk("rst_pready2", a1.pready_o, 0);
    rst = 0;

    for (int i = 0; i <= 8; i++) tv.push_back(V(0, i, 0, 0, 0, 0, 0));
    tv.push_back(V(1, 0, 1, 0, 0, 0, 0));
    tv.push_back(V(1, 2, 32'hF, 0, 0, 0, 0));
    tv.push_back(V(1, 4, 2, 0, 0, 0, 0));
    tv.push_back(V(1, 5, 1, 0, 0, 0, 0));
    tv.push_back(V(1, 6, 2, 0, 0, 0, 0));
    tv.push_back(V(1, 7, 3, 0, 0, 0, 0));
    tv.push_back(V(1, 8, 4, 0, 0, 0, 0));
    tv.push_back(V(1, 3, 1, 0, 0, 0, 0));
    tv.push_back(V(0, 2, 0, 4'h9, 0, 9, 0));
    tv.push_back(V(0, 1, 0, 0, 0, 0, 0));
    tv.push_back(V(1, 3, 9, 0, 0, 0, 0));
    tv.push_back(V(0, 1, 0, 0, 0, 7, 0));
    tv.push_back(V(1, 6, 5, 0, 0, 0, 0));
    tv.push_back(V(1, 7, 5, 0, 0, 0, 0));
    tv.push_back(V(1, 3, 6, 0, 0, 0, 0));
    tv.push_back(V(0, 1, 0, 4'h6, 0, 5, 0));
    tv.push_back(V(1, 2, 2, 0, 0, 0, 0));
    tv.push_back(V(0, 1, 0, 0, 0, 6, 0));
    tv.push_back(V(1, 2, 4, 0, 0, 0, 0));
    tv.push_back(V(0, 1, 0, 0, 0, 0, 0));
    tv.push_back(V(1, 2, 1, 0, 4'h1, 0, 0));
    tv.push_back(V(0, 2, 0, 0, 0, 9, 0));
    tv.push_back(V(0, 12, 0, 0, 0, 0, 1));
    tv.push_back(V(1, 12, 32'hFF, 0, 0, 0, 1));
    tv.push_back(V(1, 1, 32'hFF, 0, 0, 0, 1));
    tv.push_back(V(0, 32'h10, 0, 0, 0, 0, 1));
    tv.push_back(V(1, 32'h14, 7, 0, 0, 0, 1));
    tv.push_back(V(0, 4, 0, 0, 0, 2, 0));
    tv.push_back(V(0, 0, 0, 0, 0, 1, 0));
    tv.push_back(V(0, 8, 0, 0, 0, 4, 0));

    sel = 0;
    foreach (tv[i]) begin
      if (tv[i].tp != 0) begin
        trig = tv[i].tp; step(0, 0); step(0, 0);
      end
      apb(tv[i].w, tv[i].a, tv[i].d, tv[i].td, rd, er, erd);
      if (!tv[i].w) chk($sformatf("tv%0d_rd", i), rd, tv[i].rd);
      chk($sformatf("tv%0d_err", i), {31'b0, er}, {31'b0, tv[i].er});
    end

    // two wait states: write must not land before the third access cycle
    sel = 1;
    psel = 1; penable = 0; pwrite = 1; paddr = 4; pwdata = 3;
    step(0, 0);
    penable = 1;
    step(0, 0);
    chk("ws_hold1", {29'b0, u2.pth_q}, 0);
    step(0, 0);
    chk("ws_hold2", {29'b0, u2.pth_q}, 0);
    step(1, 1);
    chk("ws_commit", {29'b0, u2.pth_q}, 3);
    psel = 0; penable = 0;
    step(0, 0);
    apb(0, 12, 0, 0, rd, er, erd);
    chk("ws_bad_rd", rd, 0);
    chk("ws_bad_err", {31'b0, er}, 1);
    apb(1, 1, 5, 0, rd, er, erd);
    chk("ws_ro_err", {31'b0, er}, 1);
    apb(0, 4, 0, 0, rd, er, erd);
    chk("ws_pth_rd", rd, 3);

    // reset in the access phase of a PTH write
    sel = 0;
    psel = 1; penable = 0; pwrite = 1; paddr = 4; pwdata = 5;
    step(0, 0);
    penable = 1;
    #2;
    chk("mid_ready", a0.pready_o, 1);
    rst = 1;
    #1;
    chk("rst_drop_ready", a0.pready_o, 0);
    mreset();
    @(posedge clk);
    #1;
    psel = 0; penable = 0; rst = 0;
    step(0, 0);
    apb(0, 4, 0, 0, rd, er, erd);
    chk("post_rst_pth", rd, 0);
    apb(1, 4, 5, 0, rd, er, erd);
    chk("post_rst_wr_err", {31'b0, er}, 0);
    apb(0, 4, 0, 0, rd, er, erd);
    chk("post_rst_pth5", rd, 5);

    // random traffic with random triggers against the model
    rtrig = 1;
    for (int i = 0; i < 300; i++) begin
      sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      a = (r < 16) ? 32'(r) : (32'h100 | 32'(r - 16));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) step(0, 0);
      apb(w, a, d, 0, rd, er, erd);
      if (!w) chk("rnd_rd", rd, erd);
      chk("rnd_err", {31'b0, er}, {31'b0, merr(w, a)});
    end
    rtrig = 0;
    trig = 0;
    step(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_irq_completer.md
Name: apb_irq_completer

Overview:
APB3 completer (responder) holding the interrupt controller's register bank: status, mask, priority threshold and four per-source priorities. It captures irq trigger pulses and drives a registered interrupt request with the winning source ID. It inserts programmable wait states and flags bad addresses with pslverr. It sits between the APB fabric and the interrupt core, and answers the transactions the APB initiator generates.

Parameters:
WAIT_STATES, 0, extra access-phase cycles before pready_o is asserted (legal range 0..3)
ADDR_W, 32, paddr_i width; only bits [3:0] are decoded, and nonzero upper bits give an error
DATA_W, 32, pwdata_i/prdata_o width; unused register bits read as 0

Ports:
pclk_i  in  1  APB clock; the only clock
rst_i  in  1  reset, asynchronous, active-high
psel_i  in  1  APB select
penable_i  in  1  APB enable (access phase)
pwrite_i  in  1  1 = write, 0 = read
paddr_i  in  ADDR_W  byte-independent word index
pwdata_i  in  DATA_W  write data
prdata_o  out  DATA_W  read data, valid when pready_o=1 and the transfer is a read
pready_o  out  1  transfer complete
pslverr_o  out  1  error response, valid only with pready_o
irq_trigger_i  in  4  per-source request pulses, active-high, sampled every cycle
interrupt_o  out  1  registered interrupt request to the core
irq_id_o  out  2  winning source ID, valid while interrupt_o=1

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE, wait counter=0, all registers=0, prdata_o=0, pready_o=0, pslverr_o=0, interrupt_o=0, irq_id_o=0.
- Register map, by word index:
  - 1 ACTIVE, read-only: bit2=interrupt_o, bits1:0=irq_id_o.
  - 2 STATUS[3:0], write-1-to-clear.
  - 3 MASK[3:0]: 1 = source enabled.
  - 4 PTH[2:0].
  - 5..8 PRI0..PRI3[2:0].
  - 0 CTRL, bit0=global enable.
  - Index 9..15, or nonzero paddr_i[ADDR_W-1:4]: pslverr_o=1 with pready_o. Writes are dropped; reads return 0.
- Writes to read-only ACTIVE: pslverr_o=1 and no state change.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE→SETUP when psel_i=1 and penable_i=0.
  - SETUP→ACCESS on the next edge. Load the wait counter with WAIT_STATES.
  - In ACCESS with psel_i and penable_i high:
    - If counter≠0, decrement it and keep pready_o=0.
    - If counter=0, pready_o=1 for exactly one cycle (combinational from the state). Writes commit on that edge; prdata_o holds the registered read value in that cycle.
    - Then go to SETUP if psel_i=1 and penable_i=0 (back-to-back transfer), else IDLE.
  - psel_i dropped during ACCESS: abort to IDLE, no write, no pready_o.
  - penable_i=1 seen in IDLE (no setup phase): ignored, stay IDLE.
- Latency with WAIT_STATES=0: setup, then an access cycle with pready_o=1. That is 2 cycles per transfer, plus 1 idle cycle when the initiator deasserts psel_i.
- Paddr, pwrite and pwdata are sampled in the completing access cycle.
- STATUS[n] is set on any cycle where irq_trigger_i[n]=1, independent of APB.
- W1C clear and trigger of the same bit on the same edge: set wins.
- Eligibility: eligible[n] = CTRL[0] & STATUS[n] & MASK[n] & (PRIn > PTH). Comparison is unsigned 3-bit and strictly greater; PTH=7 blocks all sources.
- Winner: the highest PRI among eligible sources; a tie goes to the lowest index.
- interrupt_o = |eligible and irq_id_o = winner; both are registered, so they update 1 cycle after the STATUS, MASK, PRI, PTH or CTRL change.
- When no source is eligible, irq_id_o holds 0.
- Reset mid-transfer: pready_o drops immediately. The write is not committed and the FSM returns to IDLE.

Test Plan:
- Reset, then read every index 0..8 with WAIT_STATES=0 → all read 0, pready_o high exactly one cycle per read, pslverr_o=0.
- Configure CTRL=1, STATUS W1C 0xF, PTH=2, PRI0..3=1,2,3,4, MASK=0001, then pulse irq_trigger_i=1001 for one cycle → STATUS reads 0x9 and interrupt_o=0 (PRI0=1 is not >2). Then write MASK=1001 → one cycle later interrupt_o=1, irq_id_o=3, ACTIVE reads 0x7.
- With both sources eligible, PRI1=PRI2=5, MASK=0110, pulse 0110 → irq_id_o=1. Write STATUS=0010 → irq_id_o=2. Write STATUS=0100 → interrupt_o=0 next cycle.
- Issue a W1C of STATUS bit0 in the same cycle irq_trigger_i[0]=1 → STATUS[0] reads 1.
- WAIT_STATES=2: one write → pready_o rises on the 3rd access cycle, and the register is unchanged before that. Access index 12 → pslverr_o=1, read data 0. Write to ACTIVE → pslverr_o=1.
- Assert rst_i during the access phase of a write to PTH=5 → pready_o=0 at once, PTH reads 0 after reset, FSM is in IDLE, and the next transfer completes normally.
